imm_encoder: RTL and testbench

Constant materializer for the 16-bit TSC datapath; it is the narrowing counterpart of the 8→16 sign-extending immediate path. It accepts a full `WORD_SIZE` constant over a valid/ready handshake. It emits the shortest sequence of 8-bit immediate fields (ADI, LHI, or LHI+ORI) that rebuilds that constant in a register. It sits between the constant source (assembler back-end or test-program loader) and the instruction formatter.

---
 rtl/imm_encoder_pkg.sv | 13 +
 rtl/imm_classifier.sv | 13 +
 rtl/imm_encoder.sv | 90 +++++++++
 tb/tb_imm_encoder.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/imm_encoder_pkg.sv
// imm_encoder_pkg: shared constant width, immediate-kind encodings and encoder states.
package imm_encoder_pkg;
    localparam int IMM_WORD_SIZE = 16;
    localparam logic [1:0] IMM_KIND_ADI = 2'b00;
    localparam logic [1:0] IMM_KIND_LHI = 2'b01;
    localparam logic [1:0] IMM_KIND_ORI = 2'b10;
    typedef enum logic [1:0] {
        IMMENC_IDLE = 2'b00,
        IMMENC_ADI  = 2'b01,
        IMMENC_LHI  = 2'b10,
        IMMENC_ORI  = 2'b11
    } immenc_state_e;
endpackage

// File: rtl/imm_classifier.sv
// imm_classifier: splits a 16-bit constant and flags whether it fits a sign-extended byte.
module imm_classifier (
    input  logic [15:0] value_i,
    output logic        fits8_o,
    output logic        lo_zero_o,
    output logic [7:0]  hi_byte_o,
    output logic [7:0]  lo_byte_o
);
    assign fits8_o   = (&value_i[15:7]) | ~(|value_i[15:7]);
    assign lo_zero_o = ~(|value_i[7:0]);
    assign hi_byte_o = value_i[15:8];
    assign lo_byte_o = value_i[7:0];
endmodule

// File: rtl/imm_encoder.sv
// imm_encoder: turns a 16-bit constant into the shortest ADI / LHI / LHI+ORI immediate sequence.
module imm_encoder
    import imm_encoder_pkg::*;
#(
    parameter int WORD_SIZE = IMM_WORD_SIZE
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WORD_SIZE-1:0] in_value,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [1:0]           out_kind,
    output logic [7:0]           out_imm,
    output logic                 out_last,
    output logic                 busy,
    output logic [15:0]          out_count
);
    immenc_state_e state_q, state_d;
    logic [1:0]    kind_q, kind_d;
    logic [7:0]    imm_q, imm_d;
    logic          last_q, last_d;
    logic [7:0]    ori_q, ori_d;
    logic [15:0]   count_q, count_d;
    logic          fits8, lo_zero, fire;
    logic [7:0]    hi_byte, lo_byte;

    imm_classifier u_cls (
        .value_i   (in_value),
        .fits8_o   (fits8),
        .lo_zero_o (lo_zero),
        .hi_byte_o (hi_byte),
        .lo_byte_o (lo_byte)
    );

    assign in_ready  = state_q == IMMENC_IDLE;
    assign out_valid = state_q != IMMENC_IDLE;
    assign busy      = out_valid;
    assign fire      = out_valid && out_ready;
    assign out_kind  = kind_q;
    assign out_imm   = imm_q;
    assign out_last  = last_q;
    assign out_count = count_q;

    always_comb begin
        state_d = state_q;
        kind_d  = kind_q;
        imm_d   = imm_q;
        last_d  = last_q;
        ori_d   = ori_q;
        count_d = count_q;
        if (in_ready && in_valid) begin
            state_d = fits8 ? IMMENC_ADI : IMMENC_LHI;
            kind_d  = fits8 ? IMM_KIND_ADI : IMM_KIND_LHI;
            imm_d   = fits8 ? lo_byte : hi_byte;
            last_d  = fits8 | lo_zero;
            ori_d   = lo_byte;
        end else if (fire) begin
            count_d = count_q + 16'd1;
            // Only an LHI without last has a pending OR byte to emit.
            if (state_q == IMMENC_LHI && !last_q) begin
                state_d = IMMENC_ORI;
                kind_d  = IMM_KIND_ORI;
                imm_d   = ori_q;
                last_d  = 1'b1;
            end else begin
                state_d = IMMENC_IDLE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= IMMENC_IDLE;
            kind_q  <= '0;
            imm_q   <= '0;
            last_q  <= 1'b0;
            ori_q   <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            kind_q  <= kind_d;
            imm_q   <= imm_d;
            last_q  <= last_d;
            ori_q   <= ori_d;
            count_q <= count_d;
        end
    end
endmodule

// File: tb/tb_imm_encoder.sv
// tb_imm_encoder: directed vectors with a field scoreboard checked by an independent monitor.
module tb_imm_encoder;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_value = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [1:0]  out_kind;
    logic [7:0]  out_imm;
    logic        out_last;
    logic        busy;
    logic [15:0] out_count;

    int checks = 0;
    int failures = 0;
    int lasts = 0;
    logic [10:0] exp_q[$];

    localparam logic [1:0] ADI = 2'b00, LHI = 2'b01, ORI = 2'b10;

    imm_encoder dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_value  (in_value),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_kind  (out_kind),
        .out_imm   (out_imm),
        .out_last  (out_last),
        .busy      (busy),
        .out_count (out_count)
    );

    always #5 clk = ~clk;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    // Monitor: every fired field must match the head of the scoreboard.
    always @(negedge clk) begin
        if (reset_n && out_valid && out_ready) begin
            if (out_last) lasts++;
            if (exp_q.size() == 0) begin
                chk("unexpected_field", {21'd0, out_kind, out_imm, out_last}, 32'h7FF);
            end else begin
                chk("field", {21'd0, out_kind, out_imm, out_last}, {21'd0, exp_q.pop_front()});
            end
        end
    end

    task automatic expect_field(input logic [1:0] k, input logic [7:0] imm, input logic last);
        exp_q.push_back({k, imm, last});
    endtask

    task automatic send(input logic [15:0] v);
        int n = 0;
        while (!in_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (!in_ready) chk("send_timeout", 0, 1);
        in_valid = 1'b1;
        in_value = v;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (!(in_ready && exp_q.size() == 0) && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 50) chk("idle_timeout", 0, 1);
    endtask

    initial begin
        int l0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_count", out_count, 0);
        reset_n = 1'b1;
        @(posedge clk); #1;

        expect_field(ADI, 8'h7F, 1);
        send(16'h007F);
        expect_field(ADI, 8'h80, 1);
        send(16'hFF80);
        wait_idle();
        chk("count_adi", out_count, 2);

        expect_field(LHI, 8'h00, 0);
        expect_field(ORI, 8'h80, 1);
        send(16'h0080);
        chk("ready_acc+1", in_ready, 0);
        @(posedge clk); #1;
        chk("ready_acc+2", in_ready, 0);
        @(posedge clk); #1;
        chk("ready_acc+3", in_ready, 1);
        chk("count_0080", out_count, 4);

        expect_field(LHI, 8'h12, 1);
        send(16'h1200);
        wait_idle();
        chk("count_1200", out_count, 5);

        out_ready = 1'b0;
        expect_field(LHI, 8'hAB, 0);
        expect_field(ORI, 8'hCD, 1);
        expect_field(ADI, 8'h01, 1);
        send(16'hABCD);
        in_valid = 1'b1;
        in_value = 16'h0001;
        repeat (3) begin
            @(negedge clk);
            chk("stall_valid", out_valid, 1);
            chk("stall_kind", out_kind, LHI);
            chk("stall_imm", out_imm, 8'hAB);
            chk("stall_last", out_last, 0);
            chk("stall_ready", in_ready, 0);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        begin
            int n = 0;
            while (!in_ready && n < 20) begin
                @(posedge clk); #1;
                n++;
            end
            if (!in_ready) chk("held_accept_timeout", 0, 1);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        wait_idle();
        chk("count_abcd", out_count, 8);

        expect_field(LHI, 8'h12, 0);
        send(16'h1234);
        @(posedge clk); #1;
        out_ready = 1'b0;
        reset_n = 1'b0;
        @(posedge clk); #1;
        reset_n = 1'b1;
        out_ready = 1'b1;
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_ready", in_ready, 1);
        chk("mid_rst_count", out_count, 0);
        repeat (3) begin
            @(negedge clk);
            chk("no_ori_after_rst", out_valid, 0);
        end
        chk("queue_after_rst", exp_q.size(), 0);
        @(posedge clk); #1;

        l0 = lasts;
        expect_field(ADI, 8'h01, 1);
        send(16'h0001);
        expect_field(LHI, 8'h01, 1);
        send(16'h0100);
        expect_field(LHI, 8'h01, 0);
        expect_field(ORI, 8'h01, 1);
        send(16'h0101);
        wait_idle();
        chk("count_b2b", out_count, 4);
        chk("lasts_b2b", lasts - l0, 3);
        chk("queue_end", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
